serial_decoder: RTL and testbench
=================================

// Module: serial_decoder
// PURPOSE
//  Receive end of the serial link driven by the encoder: samples serialIn once per clock, detects
//  start bit, deserialises DATA_WIDTH bits, checks parity/stop, presents word on parallelOut.
//  Sits between the serial line and the parallel consumer; one bit per clock, no oversampling.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame
//  PARITY_EN   1  1: even-parity bit follows data; 0: no parity bit
//  MSB_FIRST   1  1: first data bit is parallelOut[DATA_WIDTH-1]; 0: first bit is [0]
// PORTS
//  clock        in   1           sole clock, all state updates on posedge
//  resetN       in   1           asynchronous, active-low reset
//  serialIn     in   1           serial line, idle high
//  parallelOut  out  DATA_WIDTH  last correctly received word, held until next good frame
//  dataValid    out  1           1-cycle pulse: parallelOut just updated
//  parityError  out  1           1-cycle pulse: parity mismatch, word discarded
//  frameError   out  1           1-cycle pulse: stop bit sampled 0, word discarded
//  busy         out  1           high while in any state other than IDLE
// BEHAVIOUR
//  Frame: start(0), DATA_WIDTH data bits, [even parity], stop(1). Line idles at 1.
//  Reset (async assert, sync release): state=IDLE, shift reg=0, bit count=0, parallelOut=0,
//   dataValid=parityError=frameError=busy=0. Reset mid-frame discards partial frame, no pulses.
//  FSM (registered, serialIn sampled on posedge):
//   IDLE    : serialIn==0 -> DATA, count=0; else stay.
//   DATA    : shift in bit; count==DATA_WIDTH-1 -> PARITY (PARITY_EN) or STOP; else count+1.
//   PARITY  : capture parity bit -> STOP.
//   STOP    : serialIn==1 & parity ok -> IDLE, load parallelOut, dataValid=1.
//             serialIn==1 & parity bad -> IDLE, parityError=1, parallelOut unchanged.
//             serialIn==0 -> RECOVER, frameError=1 (frame error wins over parity error).
//   RECOVER : wait for serialIn==1 -> IDLE; prevents a stuck-low line being read as starts.
//  Parity: even over data bits; error when XOR(data, parityBit)==1.
//  Latency: pulse outputs and parallelOut update on the clock edge that samples the stop bit,
//   i.e. visible the cycle after stop bit present. Frame = DATA_WIDTH+2(+1) cycles.
//  Back-to-back: start bit in the cycle immediately after stop is accepted (IDLE sees it).
//  Pulses are mutually exclusive and each last exactly one cycle.
//  busy=1 in DATA/PARITY/STOP/RECOVER; 0 in IDLE. Counter width $clog2(DATA_WIDTH), no wrap
//   beyond DATA_WIDTH-1.
// STRUCTURE
//  Shared package: state encoding constants (IDLE, DATA, PARITY, STOP, RECOVER), line idle level,
//   frame-length constants shared with encoder.
//  One sub-module natural: shift_register_sipo (DATA_WIDTH, MSB_FIRST, shift enable, clear).
//  FSM, counter, parity accumulator and output registers stay in serial_decoder.
// TESTING
//  1. Reset then idle high 20 cycles -> busy=0, no pulses, parallelOut=0x00.
//  2. Frame 0xA8 MSB first: 0,1,0,1,0,1,0,0,0,par=1,stop=1 -> parallelOut=0xA8, dataValid
//     pulse 1 cycle, no errors.
//  3. Same frame, parity bit 0 -> parityError pulse, parallelOut keeps previous value.
//  4. Frame 0x3C with stop=0, line held low 5 cycles -> frameError once, busy stays high in
//     RECOVER, no new frame until line returns high.
//  5. Frames 0x55 then 0xFF with no idle gap -> two dataValid pulses 11 cycles apart.
//  6. resetN low mid-DATA of 0x81 -> all outputs 0 immediately; next full 0x81 frame decoded.

Source files
------------

// File: rtl/serial_decoder_pkg.sv
// Shared definitions for the serial link: FSM state encoding, line levels and
// frame-length helpers common to encoder and decoder.
package serial_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DATA    = 3'd1,
        ST_PARITY  = 3'd2,
        ST_STOP    = 3'd3,
        ST_RECOVER = 3'd4
    } state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Clock cycles occupied by one frame on the line: start + data + [parity] + stop.
    function automatic int frame_cycles(input int data_width, input bit parity_en);
        return data_width + 2 + (parity_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/serial_decoder_sipo.sv
// Serial-in parallel-out shift register used by the decoder to assemble the
// payload; bit order on the line is chosen by MSB_FIRST.
module shift_register_sipo #(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  clear_i,
    input  logic                  shift_en_i,
    input  logic                  bit_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] data_q;

    // Shift the new bit in at the LSB end (MSB first on the line) or the MSB end.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            data_q <= '0;
        end else if (clear_i) begin
            data_q <= '0;
        end else if (shift_en_i) begin
            if (MSB_FIRST) data_q <= {data_q[DATA_WIDTH-2:0], bit_i};
            else           data_q <= {bit_i, data_q[DATA_WIDTH-1:1]};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/serial_decoder.sv
// Receive side of the serial link: one sample per clock, start-bit detect,
// deserialise DATA_WIDTH bits, optional even parity, stop-bit check.
// resetN asserts asynchronously; its release is expected to be synchronised
// to clock upstream.
module serial_decoder
    import serial_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  serialIn,
    output logic [DATA_WIDTH-1:0] parallelOut,
    output logic                  dataValid,
    output logic                  parityError,
    output logic                  frameError,
    output logic                  busy
);

    localparam int              CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  par_acc_q, par_acc_d;   // running XOR of data bits
    logic                  par_err_q, par_err_d;   // parity verdict for current frame
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  shift_en;
    logic                  sr_clear;
    logic [DATA_WIDTH-1:0] sr_data;

    shift_register_sipo #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_sipo (
        .clock      (clock),
        .resetN     (resetN),
        .clear_i    (sr_clear),
        .shift_en_i (shift_en),
        .bit_i      (serialIn),
        .data_o     (sr_data)
    );

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; RECOVER keeps a stuck-low line from looking like starts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (serialIn == START_BIT) state_d = ST_DATA;
            ST_DATA:    if (count_q == CNT_LAST)   state_d = PARITY_EN ? ST_PARITY : ST_STOP;
            ST_PARITY:  state_d = ST_STOP;
            ST_STOP:    state_d = (serialIn == STOP_BIT) ? ST_IDLE : ST_RECOVER;
            ST_RECOVER: if (serialIn == LINE_IDLE) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Per-state actions: counter, parity, shift control and next output values.
    always_comb begin
        count_d   = count_q;
        par_acc_d = par_acc_q;
        par_err_d = par_err_q;
        word_d    = word_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        shift_en  = 1'b0;
        sr_clear  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (serialIn == START_BIT) begin
                    count_d   = '0;
                    par_acc_d = 1'b0;
                    par_err_d = 1'b0;
                    sr_clear  = 1'b1;
                end
            end
            ST_DATA: begin
                shift_en  = 1'b1;
                par_acc_d = par_acc_q ^ serialIn;
                if (count_q != CNT_LAST) count_d = count_q + CNT_W'(1);
            end
            ST_PARITY: begin
                par_err_d = par_acc_q ^ serialIn;
            end
            ST_STOP: begin
                // A bad stop bit outranks a parity mismatch.
                if (serialIn != STOP_BIT) begin
                    ferr_d = 1'b1;
                end else if (par_err_q) begin
                    perr_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    word_d  = sr_data;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count_q   <= '0;
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            par_acc_q <= par_acc_d;
            par_err_q <= par_err_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign parallelOut = word_q;
    assign dataValid   = valid_q;
    assign parityError = perr_q;
    assign frameError  = ferr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_decoder.sv
// Directed bench for serial_decoder. Frame-level expectations are scheduled
// into per-cycle tables as frames are driven; one process compares every cycle.
module tb_serial_decoder;

    localparam int NCYC = 1024;

    logic       clock = 1'b0;
    logic       resetN;
    logic       serialIn;
    logic [7:0] parallelOut;
    logic       dataValid, parityError, frameError, busy;

    serial_decoder #(.DATA_WIDTH(8), .PARITY_EN(1'b1), .MSB_FIRST(1'b1)) dut (
        .clock       (clock),
        .resetN      (resetN),
        .serialIn    (serialIn),
        .parallelOut (parallelOut),
        .dataValid   (dataValid),
        .parityError (parityError),
        .frameError  (frameError),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;   // number of rising edges so far
    always @(posedge clock) cyc <= cyc + 1;

    // Expectations indexed by the rising edge after which they hold.
    bit       exp_dv   [NCYC];
    bit       exp_pe   [NCYC];
    bit       exp_fe   [NCYC];
    bit       exp_busy [NCYC];
    bit       word_v   [NCYC];
    bit [7:0] word_w   [NCYC];

    int checks = 0;
    int errors = 0;
    int dv_cycles[$];
    bit [7:0] model_word = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the scheduled model.
    always @(negedge clock) begin
        if (!resetN) begin
            model_word = 8'h00;
        end else if (cyc < NCYC) begin
            if (word_v[cyc]) model_word = word_w[cyc];
            chk("dataValid",   dataValid,   exp_dv[cyc]);
            chk("parityError", parityError, exp_pe[cyc]);
            chk("frameError",  frameError,  exp_fe[cyc]);
            chk("busy",        busy,        exp_busy[cyc]);
            chk("parallelOut", parallelOut, model_word);
            if (dataValid === 1'b1) dv_cycles.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            serialIn = 1'b1;
        end
    endtask

    // Drive one frame, MSB first; flip_par corrupts parity, stop is the stop
    // bit value, low_after extra low cycles follow a bad stop bit.
    task automatic send_frame(input bit [7:0] w, input bit flip_par, input bit stop,
                              input int low_after);
        int s;
        bit par;
        par = (($countones(w) % 2) == 1) ^ flip_par;
        @(negedge clock);
        s = cyc + 1;   // edge that samples the start bit
        for (int c = s; c <= s + 9; c++) exp_busy[c] = 1'b1;
        if (!stop) begin
            exp_fe[s+10] = 1'b1;
            for (int c = s + 10; c <= s + 10 + low_after; c++) exp_busy[c] = 1'b1;
        end else if (flip_par) begin
            exp_pe[s+10] = 1'b1;
        end else begin
            exp_dv[s+10] = 1'b1;
            word_v[s+10] = 1'b1;
            word_w[s+10] = w;
        end
        serialIn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            serialIn = w[7-i];
        end
        @(negedge clock);
        serialIn = par;
        @(negedge clock);
        serialIn = stop;
        repeat (low_after) begin
            @(negedge clock);
            serialIn = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, s;
        bit [7:0] w81;
        resetN   = 1'b0;
        serialIn = 1'b1;

        // 1. reset state and long idle
        repeat (2) @(negedge clock);
        #1;
        chk("reset parallelOut", parallelOut, 8'h00);
        chk("reset busy", busy, 1'b0);
        chk("reset pulses", {dataValid, parityError, frameError}, 3'b000);
        @(negedge clock);
        #2 resetN = 1'b1;
        idle(20);
        #1;
        chk("idle parallelOut", parallelOut, 8'h00);
        chk("idle busy", busy, 1'b0);

        // 2. good frame 0xA8
        send_frame(8'hA8, 1'b0, 1'b1, 0);
        idle(3);
        #1;
        chk("A8 word", parallelOut, 8'hA8);
        chk("A8 dv count", dv_cycles.size(), 1);

        // 3. same frame, parity bit wrong
        send_frame(8'hA8, 1'b1, 1'b1, 0);
        idle(3);
        #1;
        chk("parity word kept", parallelOut, 8'hA8);
        chk("parity dv count", dv_cycles.size(), 1);

        // 4. 0x3C with bad stop, line held low
        send_frame(8'h3C, 1'b0, 1'b0, 5);
        #1;
        chk("recover busy", busy, 1'b1);
        idle(4);
        #1;
        chk("recover exit busy", busy, 1'b0);
        chk("frame word kept", parallelOut, 8'hA8);

        // 5. back-to-back 0x55, 0xFF
        n0 = dv_cycles.size();
        send_frame(8'h55, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 0);
        idle(3);
        #1;
        chk("b2b dv count", dv_cycles.size(), n0 + 2);
        if (dv_cycles.size() == n0 + 2)
            chk("b2b spacing", dv_cycles[n0+1] - dv_cycles[n0], 11);
        chk("b2b word", parallelOut, 8'hFF);

        // 6. reset in the middle of 0x81
        w81 = 8'h81;
        @(negedge clock);
        s = cyc + 1;
        for (int c = s; c <= s + 3; c++) exp_busy[c] = 1'b1;
        serialIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            serialIn = w81[7-i];
        end
        @(negedge clock);
        #2 resetN = 1'b0;
        serialIn = 1'b1;
        #1;
        chk("midreset parallelOut", parallelOut, 8'h00);
        chk("midreset busy", busy, 1'b0);
        chk("midreset pulses", {dataValid, parityError, frameError}, 3'b000);
        repeat (2) @(negedge clock);
        #2 resetN = 1'b1;
        idle(3);
        send_frame(8'h81, 1'b0, 1'b1, 0);
        idle(3);
        #1;
        chk("81 word", parallelOut, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
